stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, W-bit stream multiplexer with valid/ready handshaking and a registered output stage. It selects one of N_IN producer channels, either by an explicit select input (fixed mode) or by round-robin arbitration among requesting inputs, and forwards one beat per grant. It sits between multiple producer streams and a single consumer, and supersedes the combinational 4:1 bit mux wherever back-pressure or fair sharing is needed.

## Interface
- N_IN, 4: number of input channels; 2..16.
- WIDTH, 8: data bits per channel; ≥1.
- SEL_W, $clog2(N_IN): select/index width (derived, not overridden).
- Reset is asynchronous and active-low; the block uses one clock.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rr_en  input  1  1 = round-robin mode, 0 = fixed mode (use sel).
- sel  input  SEL_W  channel chosen in fixed mode; ignored when rr_en=1.
- in_valid  input  N_IN  per-channel beat available.
- in_ready  output  N_IN  per-channel beat accepted this cycle (combinational).
- in_data  input  N_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data.
- out_idx  output  SEL_W  source channel of the current out_data.

## Operation
- The output stage has one register: the beat is accepted when it is empty or drains this cycle. can_load = !out_valid || out_ready.
- Fixed mode (rr_en=0):
  - grant = one-hot(sel) & in_valid.
  - sel ≥ N_IN grants nothing.
- Round-robin mode (rr_en=1):
  - grant is the first asserted in_valid found scanning upward from (last+1) mod N_IN, with wrap.
  - last is the most recently transferred index.
- Transfers:
  - in_ready[i] = grant[i] && can_load. At most one bit is set.
  - On in_valid[i] && in_ready[i], the output register loads out_data ← in_data[i], out_idx ← i, out_valid ← 1.
  - In round-robin mode, last ← i only on an actual transfer. A stalled grant does not advance the pointer.
- Drain: on out_valid && out_ready with no new load, out_valid ← 0. out_data and out_idx hold their values.
- Stability: while out_valid && !out_ready, out_data and out_idx are held constant.
- Mode switching: rr_en and sel may change on any cycle and take effect on that cycle's grant. The pointer last is preserved across mode changes and is not updated by fixed-mode transfers.
- Arithmetic: index wrap is computed modulo N_IN, not 2^SEL_W, so a non-power-of-two N_IN never selects an invalid index.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, last=N_IN-1 (so channel 0 has highest priority first), in_ready=0.
- Reset is asynchronous on assertion and synchronous-safe on release. A beat in flight at reset assertion is discarded.
- Latency: a beat accepted in cycle t appears with out_valid=1 at cycle t+1.
- Throughput: 1 beat/cycle when out_ready is held at 1 (simultaneous drain and load).
- in_ready depends combinationally on in_valid, rr_en, sel and out_ready. There is no combinational path from in_data to any output.
- Producers must hold in_valid/in_data until their in_ready is seen. The block tolerates a producer dropping in_valid before it is granted.

## Structure
- Shared package stream_mux_pkg:
  - function clog2_min1 (returns ≥1 for N_IN=1 safety);
  - localparam limits N_IN_MAX=16;
  - no typedefs beyond a WIDTH-agnostic index type.
- Sub-module rr_arbiter:
  - inputs: N_IN request vector, last pointer, advance strobe;
  - outputs: one-hot grant and encoded index.
  - It is reusable by other multi-master blocks.
- The top level holds the fixed/RR grant mux, the handshake logic and the output register.

## Test plan
- Reset: assert rst_n=0 mid-transfer with out_valid=1 → out_valid, out_data, out_idx and in_ready are all 0 immediately. After release, the first RR grant goes to channel 0.
- Fixed mode: rr_en=0, sel=2, all in_valid=1, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100 and out_data=8'hA5, out_idx=2 one cycle later. With sel=5 (N_IN=4 → invalid), in_ready=0.
- Round-robin fairness: rr_en=1, all in_valid=1, out_ready=1 for 8 cycles → out_idx sequence is 0,1,2,3,0,1,2,3 at one beat/cycle.
- Back-pressure: out_ready=0 with out_valid=1 for 5 cycles → out_data and out_idx are unchanged, in_ready=0 throughout and the pointer does not advance. Raising out_ready loads the next channel in that same cycle.
- Sparse requests with wrap: last=3, only in_valid[1] and in_valid[2] set → grant goes to 1, then 2, then 1.
- Mode switch: run RR until last=1, switch to fixed sel=3 for 2 beats, then return to RR with all valid → the next RR grant is 2.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer and its round-robin arbiter.
//   N_IN_MAX   : largest supported number of input channels
//   idx_t      : channel index type wide enough for any N_IN up to N_IN_MAX
//   clog2_min1 : ceil(log2(n)) but never less than 1, so a single-channel
//                instance still gets a 1-bit index bus
package stream_mux_pkg;

  localparam int N_IN_MAX = 16;

  typedef logic [$clog2(N_IN_MAX)-1:0] idx_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant among N_IN requesters.
//   req_i        : request vector, one bit per channel
//   last_i       : index of the most recently served channel
//   advance_i    : high when the current grant actually transfers
//   grant_o      : one-hot grant (zero when nothing requests)
//   idx_o        : encoded index of grant_o
//   last_next_o  : pointer value to store for the next cycle
// The pointer register itself lives in the instantiating block so that it
// can be shared with other grant sources (e.g. a fixed-select path).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = clog2_min1(N_IN)
) (
  input  logic [N_IN-1:0]  req_i,
  input  logic [SEL_W-1:0] last_i,
  input  logic             advance_i,
  output logic [N_IN-1:0]  grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic [SEL_W-1:0] last_next_o
);

  // One extra bit so last+k (at most 2*N_IN-1) never overflows before the
  // modulo-N_IN correction.
  logic [SEL_W:0] cand;

  // Scan from the farthest candidate back to the nearest; the last hit
  // written wins, which is the first requester after last_i.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_IN; k >= 1; k--) begin
      cand = {1'b0, last_i} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N_IN)) begin
        cand = cand - (SEL_W+1)'(N_IN);
      end
      if (req_i[cand[SEL_W-1:0]]) begin
        grant_o                    = '0;
        grant_o[cand[SEL_W-1:0]]   = 1'b1;
        idx_o                      = cand[SEL_W-1:0];
      end
    end
  end

  assign last_next_o = advance_i ? idx_o : last_i;

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_IN-input, WIDTH-bit valid/ready stream multiplexer with a
// single registered output stage.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   rr_en_i      : 1 = round-robin among requesters, 0 = use sel_i
//   sel_i        : fixed-mode channel; values >= N_IN grant nothing
//   in_valid_i   : per-channel beat available
//   in_ready_o   : per-channel accept (combinational, at most one bit)
//   in_data_i    : channel i at [i*WIDTH +: WIDTH]
//   out_valid_o  : output register holds a beat
//   out_ready_i  : consumer accepts the beat
//   out_data_o   : registered data
//   out_idx_o    : source channel of out_data_o
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2_min1(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rr_en_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_IN-1:0]       in_valid_i,
  output logic [N_IN-1:0]       in_ready_o,
  input  logic [N_IN*WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [SEL_W-1:0]      out_idx_o
);

  logic [N_IN-1:0]  fixed_grant;
  logic [N_IN-1:0]  rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic [N_IN-1:0]  grant;
  logic             can_load;
  logic             xfer;
  logic [SEL_W-1:0] xfer_idx;
  logic [WIDTH-1:0] xfer_data;

  logic [SEL_W-1:0] last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_idx_q, out_idx_d;

  // Equality against each legal index means an out-of-range select simply
  // matches no channel.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_fixed
    assign fixed_grant[gi] = in_valid_i[gi] && (sel_i == SEL_W'(gi));
  end

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i       (in_valid_i),
    .last_i      (last_q),
    .advance_i   (rr_en_i && xfer),
    .grant_o     (rr_grant),
    .idx_o       (rr_idx),
    .last_next_o (last_d)
  );

  assign grant    = rr_en_i ? rr_grant : fixed_grant;
  assign can_load = !out_valid_q || out_ready_i;
  // Held at zero while reset is asserted so no producer sees a phantom accept.
  assign in_ready_o = (rst_n && can_load) ? grant : '0;
  assign xfer       = |in_ready_o;

  // grant is one-hot, so this loop is a plain encoder plus data select.
  always_comb begin
    xfer_idx  = '0;
    xfer_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        xfer_idx  = SEL_W'(i);
        xfer_data = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      out_idx_d   = xfer_idx;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // last_q resets to N_IN-1 so channel 0 is first in line after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= SEL_W'(N_IN - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the mux rules.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rr_en;
  logic [SW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_idx;

  // Non-power-of-two instance for invalid-select and modulo-wrap checks.
  logic          rr_en3;
  logic [1:0]    sel3;
  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [3*W-1:0] in_data3;
  logic          out_valid3;
  logic          out_ready3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_idx3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_last;
  bit m_valid;
  int m_data;
  int m_idx;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_IN(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rr_en_i    (rr_en),
    .sel_i      (sel),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_idx_o  (out_idx)
  );

  stream_mux_rr #(.N_IN(3), .WIDTH(W)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rr_en_i    (rr_en3),
    .sel_i      (sel3),
    .in_valid_i (in_valid3),
    .in_ready_o (in_ready3),
    .in_data_i  (in_data3),
    .out_valid_o(out_valid3),
    .out_ready_i(out_ready3),
    .out_data_o (out_data3),
    .out_idx_o  (out_idx3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Which channel wins this cycle by the stated rules, or -1 for none.
  function automatic int model_grant(input bit rr, input int s, input bit [N-1:0] v, input int last);
    if (!rr) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 0;
    m_data  = 0;
    m_idx   = 0;
  endtask

  // Called just after a rising edge: drive, check in_ready, clock, check outputs.
  task automatic step(input bit rr, input int s, input bit [N-1:0] v, input bit ordy, input bit [31:0] data);
    int  g;
    bit  ld;
    rr_en     = rr;
    sel       = SW'(s);
    in_valid  = v;
    out_ready = ordy;
    in_data   = data;
    #1;
    g  = model_grant(rr, s, v, m_last);
    ld = (g >= 0) && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), ld ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    #1;
    if (ld) begin
      m_valid = 1;
      m_data  = int'((data >> (8 * g)) & 32'hFF);
      m_idx   = g;
      if (rr) m_last = g;
      $display("beat mode=%s ch=%0d data=%02h", rr ? "rr" : "fix", g, m_data);
    end else if (ordy) begin
      m_valid = 0;
    end
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_idx",   32'(out_idx),   32'(m_idx));
  endtask

  initial begin
    rst_n      = 1'b0;
    rr_en      = 1'b1;
    sel        = '0;
    in_valid   = '1;
    in_data    = 32'h0;
    out_ready  = 1'b1;
    rr_en3     = 1'b0;
    sel3       = 2'd0;
    in_valid3  = 3'b000;
    in_data3   = '0;
    out_ready3 = 1'b1;
    model_reset();

    // Reset state with requests pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);

    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    // Three-channel instance: sel=3 is out of range; RR wraps 2 -> 0
    rr_en3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; #1;
    check("n3_sel_invalid", 32'(in_ready3), 32'd0);
    sel3 = 2'd2; #1;
    check("n3_sel2", 32'(in_ready3), 32'b100);
    rr_en3 = 1'b1; #1;
    check("n3_rr_first", 32'(in_ready3), 32'b001);
    in_valid3 = 3'b000;
    @(posedge clk);
    #1;

    // Fixed mode, sel=2
    step(0, 2, 4'hF, 1, 32'h44A52211);
    check("fix_data", 32'(out_data), 32'hA5);
    check("fix_idx",  32'(out_idx),  32'd2);

    // Round-robin fairness: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 4'hF, 1, $urandom);
      check("rr_seq", 32'(out_idx), 32'(k % N));
    end

    // Back-pressure
    step(1, 0, 4'hF, 1, $urandom);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 4'hF, 0, $urandom);
      check("bp_hold_idx", 32'(out_idx), 32'd0);
    end
    step(1, 0, 4'hF, 1, $urandom);
    check("bp_release", 32'(out_idx), 32'd1);

    // Sparse requests with wrap, starting from last=3
    step(1, 0, 4'hF, 1, $urandom);
    step(1, 0, 4'hF, 1, $urandom);
    step(1, 0, 4'b0110, 1, $urandom);
    check("sparse0", 32'(out_idx), 32'd1);
    step(1, 0, 4'b0110, 1, $urandom);
    check("sparse1", 32'(out_idx), 32'd2);
    step(1, 0, 4'b0110, 1, $urandom);
    check("sparse2", 32'(out_idx), 32'd1);

    // Mode switch: fixed beats leave the RR pointer at 1
    step(0, 3, 4'hF, 1, $urandom);
    step(0, 3, 4'hF, 1, $urandom);
    check("fix_sel3", 32'(out_idx), 32'd3);
    step(1, 0, 4'hF, 1, $urandom);
    check("rr_resume", 32'(out_idx), 32'd2);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), N'($urandom),
           ($urandom_range(0, 3) != 0), $urandom);
    end

    // Reset asserted mid-cycle while a beat is stalled in the output register
    step(1, 0, 4'hF, 1, $urandom);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    check("mid_rst_idx",   32'(out_idx),   32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 4'hF, 1, 32'h0BADF00D);
    check("post_rst_first", 32'(out_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
